// File: rtl/game_pkg.sv
// Shared definitions for the game's framebuffer-side logic: arbiter FSM states,
// default coordinate widths and the screen geometry.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int X_W_DEF     = 8;
  localparam int Y_W_DEF     = 7;
  localparam int COL_W_DEF   = 3;
  localparam int SIZE_W_DEF  = 4;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Width of an index into n items; never below 1 so single-entry builds still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_arbiter_rr_select.sv
// Combinational round-robin selector: the first set request at or after ptr,
// wrapping modulo NUM_REQ, is returned one-hot.
module rr_select
  import game_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               any
);

  int best_off;
  int sel;

  always_comb begin
    best_off = NUM_REQ;
    sel      = 0;
    win      = '0;
    any      = |req;
    // Distance from ptr going upwards; the smallest distance among set requests wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (((i + NUM_REQ - int'(ptr)) % NUM_REQ) < best_off)) begin
        best_off = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
        sel      = i;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      win[i] = any && (sel == i);
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Shares the framebuffer write port between object controllers: grants one
// requester at a time round-robin and scans its rectangle one pixel per cycle.
module draw_arbiter
  import game_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int COL_W   = COL_W_DEF,
  parameter int SIZE_W  = SIZE_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*X_W-1:0]    req_x,
  input  logic [NUM_REQ*Y_W-1:0]    req_y,
  input  logic [NUM_REQ*SIZE_W-1:0] req_w,
  input  logic [NUM_REQ*SIZE_W-1:0] req_h,
  input  logic [NUM_REQ*COL_W-1:0]  req_colour,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      plot,
  output logic [X_W-1:0]            out_x,
  output logic [Y_W-1:0]            out_y,
  output logic [COL_W-1:0]          out_colour
);

  localparam int PTR_W = idx_w(NUM_REQ);

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     win_idx_q, win_idx_d;
  logic [X_W-1:0]       x0_q, x0_d;
  logic [Y_W-1:0]       y0_q, y0_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [SIZE_W-1:0]    w_q, w_d, h_q, h_d;
  logic [SIZE_W-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic                 busy_q, busy_d, plot_q, plot_d;
  logic [X_W-1:0]       out_x_q, out_x_d;
  logic [Y_W-1:0]       out_y_q, out_y_d;
  logic [COL_W-1:0]     out_col_q, out_col_d;

  logic [NUM_REQ-1:0]   rr_win;
  logic                 rr_any;
  logic [PTR_W-1:0]     rr_idx;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [SIZE_W-1:0]    sel_w, sel_h;
  logic [COL_W-1:0]     sel_col;
  logic [SIZE_W-1:0]    nxt_cx, nxt_cy;
  logic                 last_col, last_row;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_select (
    .req (req),
    .ptr (ptr_q),
    .win (rr_win),
    .any (rr_any)
  );

  always_comb begin
    rr_idx  = '0;
    sel_x   = '0;
    sel_y   = '0;
    sel_w   = '0;
    sel_h   = '0;
    sel_col = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_win[i]) rr_idx = PTR_W'(i);
      if (win_idx_q == PTR_W'(i)) begin
        sel_x   = req_x[i*X_W +: X_W];
        sel_y   = req_y[i*Y_W +: Y_W];
        sel_w   = req_w[i*SIZE_W +: SIZE_W];
        sel_h   = req_h[i*SIZE_W +: SIZE_W];
        sel_col = req_colour[i*COL_W +: COL_W];
      end
    end
  end

  // cx/cy index the pixel currently on the outputs; the registers load the next one.
  assign nxt_cx   = cx_q + SIZE_W'(1);
  assign nxt_cy   = cy_q + SIZE_W'(1);
  assign last_col = (cx_q == w_q - SIZE_W'(1));
  assign last_row = (cy_q == h_q - SIZE_W'(1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_idx_d = win_idx_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    col_d     = col_q;
    w_d       = w_q;
    h_d       = h_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    done_d    = '0;
    plot_d    = 1'b0;
    out_x_d   = out_x_q;
    out_y_d   = out_y_q;
    out_col_d = out_col_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          state_d   = ST_LATCH;
          win_idx_d = rr_idx;
          grant_d   = rr_win;
          busy_d    = 1'b1;
        end
      end
      ST_LATCH: begin
        x0_d  = sel_x;
        y0_d  = sel_y;
        col_d = sel_col;
        w_d   = sel_w;
        h_d   = sel_h;
        cx_d  = '0;
        cy_d  = '0;
        if (sel_w == '0 || sel_h == '0) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end else begin
          state_d   = ST_SCAN;
          plot_d    = 1'b1;
          out_x_d   = sel_x;
          out_y_d   = sel_y;
          out_col_d = sel_col;
        end
      end
      ST_SCAN: begin
        if (last_col) begin
          cx_d = '0;
          if (last_row) begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end else begin
            cy_d    = nxt_cy;
            plot_d  = 1'b1;
            out_x_d = x0_q;
            out_y_d = y0_q + Y_W'(nxt_cy);
          end
        end else begin
          cx_d    = nxt_cx;
          plot_d  = 1'b1;
          out_x_d = x0_q + X_W'(nxt_cx);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_q + PTR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_idx_q <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      plot_q    <= 1'b0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      out_col_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_idx_q <= win_idx_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      plot_q    <= plot_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      out_col_q <= out_col_d;
    end
  end

  // Rectangle parameters are only meaningful after LATCH, so they carry no reset.
  always_ff @(posedge clk) begin
    x0_q  <= x0_d;
    y0_q  <= y0_d;
    col_q <= col_d;
    w_q   <= w_d;
    h_q   <= h_d;
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign plot       = plot_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_colour = out_col_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: a transaction-level model predicts service
// order, pixels and completion timing; a monitor checks every plot/done cycle.
module tb_draw_arbiter;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*XW-1:0] req_x;
  logic [N*YW-1:0] req_y;
  logic [N*SW-1:0] req_w;
  logic [N*SW-1:0] req_h;
  logic [N*CW-1:0] req_colour;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic            plot;
  logic [XW-1:0]   out_x;
  logic [YW-1:0]   out_y;
  logic [CW-1:0]   out_colour;

  draw_arbiter #(
    .NUM_REQ (N), .X_W (XW), .Y_W (YW), .COL_W (CW), .SIZE_W (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .plot       (plot),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    int         x;
    int         y;
    int         col;
    logic [N-1:0] vec;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  int   fx[N], fy[N], fw[N], fh[N], fc[N];
  int   ptr_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pack_fields();
    for (int i = 0; i < N; i++) begin
      req_x[i*XW +: XW]      = XW'(fx[i]);
      req_y[i*YW +: YW]      = YW'(fy[i]);
      req_w[i*SW +: SW]      = SW'(fw[i]);
      req_h[i*SW +: SW]      = SW'(fh[i]);
      req_colour[i*CW +: CW] = CW'(fc[i]);
    end
  endtask

  // Model arbitration: lowest pending index at or above the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] m);
    for (int off = 0; off < N; off++) begin
      if (m[(ptr_m + off) % N]) return (ptr_m + off) % N;
    end
    return -1;
  endfunction

  // Queue the expected pixels (row-major, wrapped) and completion; returns occupancy.
  function automatic int push_service(input int i);
    exp_t e;
    for (int r = 0; r < fh[i]; r++) begin
      for (int c = 0; c < fw[i]; c++) begin
        e.is_done = 1'b0;
        e.x       = (fx[i] + c) % 256;
        e.y       = (fy[i] + r) % 128;
        e.col     = fc[i];
        e.vec     = 4'b0001 << i;
        sbq.push_back(e);
      end
    end
    e.is_done = 1'b1;
    e.x       = 0;
    e.y       = 0;
    e.col     = 0;
    e.vec     = 4'b0001 << i;
    sbq.push_back(e);
    return fw[i] * fh[i] + 3;
  endfunction

  always @(negedge clk) begin
    if (mon_en && (plot || done != '0)) begin
      if (sbq.size() == 0) begin
        check("spurious_output", {27'd0, plot, done}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.is_done) begin
          check("done_vec", 32'(done), 32'(mon_e.vec));
          check("done_grant", 32'(grant), 32'(mon_e.vec));
          check("done_noplot", 32'(plot), 32'd0);
        end else begin
          check("pix_x", 32'(out_x), mon_e.x);
          check("pix_y", 32'(out_y), mon_e.y);
          check("pix_colour", 32'(out_colour), mon_e.col);
          check("pix_grant", 32'(grant), 32'(mon_e.vec));
          check("pix_nodone", 32'(done), 32'd0);
        end
      end
    end
  end

  // Raise the mask and service nserv rectangles; hold=1 keeps requests up until
  // nserv completions, otherwise each requester drops on its own done.
  task automatic run_batch(input logic [N-1:0] mask, input bit hold, input int nserv, input bit tamper);
    logic [N-1:0] m;
    int total, first, w, start, ndone, lastdone, g, npl;
    bit tampered;
    m = mask; total = 0; first = -1;
    for (int s = 0; s < nserv; s++) begin
      w = pick(m);
      if (first < 0) first = w;
      total += push_service(w);
      ptr_m = (w + 1) % N;
      if (!hold) m[w] = 1'b0;
    end
    pack_fields();
    req = mask;
    start = cyc; ndone = 0; lastdone = 0; g = 0; npl = 0; tampered = 1'b0;
    while (ndone < nserv && g < 3000) begin
      @(negedge clk);
      g++;
      if (g == 1) check("grant_latency", 32'(grant), 32'(4'b0001 << first));
      if (plot) npl++;
      if (tamper && !tampered && npl == 2) begin
        fx[0] = fx[0] + 37;
        fy[0] = fy[0] + 5;
        pack_fields();
        req[0] = 1'b0;
        tampered = 1'b1;
      end
      if (done != '0) begin
        ndone++;
        lastdone = cyc;
        if (!hold) req = req & ~done;
        else if (ndone == nserv) req = '0;
      end
    end
    if (ndone < nserv) begin
      check("timeout_done", ndone, nserv);
      req = '0;
    end else begin
      check("occupancy", lastdone - start, total - 1);
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_plot", 32'(plot), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_plot"}, 32'(plot), 32'd0);
    check({tag, "_x"}, 32'(out_x), 32'd0);
    check({tag, "_y"}, 32'(out_y), 32'd0);
    check({tag, "_colour"}, 32'(out_colour), 32'd0);
  endtask

  task automatic rand_fields(input int i, input int wmin);
    fx[i] = $urandom_range(0, 255);
    fy[i] = $urandom_range(0, 127);
    fw[i] = $urandom_range(wmin, 7);
    fh[i] = $urandom_range(wmin, 7);
    fc[i] = $urandom_range(0, 7);
  endtask

  initial begin
    int g, npl, nserv;
    logic [N-1:0] mask;
    bit hold;
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < N; i++) begin
      fx[i] = 0; fy[i] = 0; fw[i] = 0; fh[i] = 0; fc[i] = 0;
    end
    pack_fields();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset  = 1'b0;
    ptr_m  = 0;
    mon_en = 1'b1;
    @(negedge clk);

    // Held simultaneous requests, unit rectangles: expected order 0,1,3,0,1,3.
    for (int i = 0; i < N; i++) begin
      rand_fields(i, 1);
      fw[i] = 1; fh[i] = 1;
    end
    run_batch(4'b1011, 1'b1, 6, 1'b0);

    fx[1] = 10; fy[1] = 20; fw[1] = 3; fh[1] = 2; fc[1] = 4;
    run_batch(4'b0010, 1'b0, 1, 1'b0);

    fx[2] = 254; fy[2] = 126; fw[2] = 4; fh[2] = 3; fc[2] = 5;
    run_batch(4'b0100, 1'b0, 1, 1'b0);

    fx[3] = 40; fy[3] = 50; fw[3] = 0; fh[3] = 5; fc[3] = 7;
    run_batch(4'b1000, 1'b0, 1, 1'b0);

    fx[0] = 100; fy[0] = 60; fw[0] = 3; fh[0] = 3; fc[0] = 2;
    run_batch(4'b0001, 1'b0, 1, 1'b1);

    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < N; i++) rand_fields(i, 0);
      mask  = N'($urandom_range(1, 15));
      hold  = ($urandom_range(0, 3) == 0);
      nserv = hold ? $urandom_range(1, 6) : $countones(mask);
      run_batch(mask, hold, nserv, 1'b0);
    end

    // Leave ptr at 3, then reset in the middle of a 4x4 scan with 2 and 3 pending.
    rand_fields(2, 1);
    run_batch(4'b0100, 1'b0, 1, 1'b0);
    fx[0] = 20; fy[0] = 30; fw[0] = 4; fh[0] = 4; fc[0] = 6;
    rand_fields(2, 1);
    rand_fields(3, 1);
    pack_fields();
    mon_en = 1'b0;
    req = 4'b0001;
    g = 0; npl = 0;
    while (npl < 4 && g < 100) begin
      @(negedge clk);
      g++;
      if (plot) npl++;
    end
    check("reset_scan_reached", npl, 4);
    reset = 1'b1;
    req   = 4'b1100;
    @(negedge clk);
    check_all_zero("midscan_reset");
    reset  = 1'b0;
    ptr_m  = 0;
    mon_en = 1'b1;
    run_batch(4'b1100, 1'b0, 2, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
